// File: rtl/serv_exec_seq_pkg.sv
// Shared definitions for the bit-serial execution sequencer: the state
// encoding and a helper giving the last counter index of a pass.
package serv_exec_seq_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DEC   = 3'd2,
    ST_INIT  = 3'd3,
    ST_MEM   = 3'd4,
    ST_RUN   = 3'd5,
    ST_TRAP  = 3'd6
  } state_e;

  localparam int CNT_W = 5;

  // Counter value on the last cycle of a pass (32/w cycles, step w).
  function automatic logic [CNT_W-1:0] last_idx(input int w);
    return CNT_W'(32 - w);
  endfunction

endpackage

// File: rtl/serv_exec_seq_bit_cnt.sv
// serv_bit_cnt: 5-bit bit-index counter stepping by W per enabled cycle.
// Clear wins over enable; o_last flags the final cycle of a 32-bit pass.
module serv_bit_cnt
  import serv_exec_seq_pkg::*;
#(
  parameter int W = 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, step with natural 5-bit wrap, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)     cnt_d = '0;
    else if (i_en) cnt_d = cnt_q + CNT_W'(W);
  end

  // Count register.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_cnt  = cnt_q;
  assign o_last = (cnt_q == last_idx(W));

endmodule

// File: rtl/serv_exec_seq.sv
// serv_exec_seq: sequences one bit-serial instruction through
// FETCH, DEC, optional INIT pass, optional MEM access and the RUN pass.
// Optional feature macro SERV_EXEC_MISALIGN_EN: misaligned jump targets and
// data accesses divert the instruction into a TRAP pass instead of MEM/RUN.
module serv_exec_seq
  import serv_exec_seq_pkg::*;
#(
  parameter int W = 1
) (
  input  logic       clk,
  input  logic       i_rst_n,
  output logic       o_ibus_cyc,
  input  logic       i_ibus_ack,
  output logic       o_dec_en,
  output logic       o_rf_rreq,
  input  logic       i_rf_ready,
  input  logic       i_branch_op,
  input  logic       i_cond_branch,
  input  logic       i_mem_op,
  input  logic       i_slt_op,
  input  logic       i_rd_op,
  input  logic       i_mem_word,
  input  logic       i_mem_half,
  input  logic       i_alu_cmp,
  input  logic [1:0] i_lsb,
  output logic       o_dbus_cyc,
  input  logic       i_dbus_ack,
  output logic [4:0] o_cnt,
  output logic       o_cnt_en,
  output logic       o_init,
  output logic       o_cnt_done,
  output logic       o_take,
  output logic       o_rf_wen,
  output logic       o_pc_en,
  output logic       o_trap
);

  state_e state_q, state_d;
  logic   take_q, take_d;
  logic   cnt_clr;
  logic   cnt_last;
  logic   take_now;
  logic   misalign;

  serv_bit_cnt #(.W(W)) u_bit_cnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr),
    .i_en    (o_cnt_en),
    .o_cnt   (o_cnt),
    .o_last  (cnt_last)
  );

  // Branch decision as evaluated on the last INIT cycle.
  assign take_now = i_branch_op & (~i_cond_branch | i_alu_cmp);

`ifdef SERV_EXEC_MISALIGN_EN
  // Misaligned jump target or data address detected on the last INIT cycle.
  assign misalign = (i_branch_op & take_now & i_lsb[1])
                  | (i_mem_op & i_mem_word & (i_lsb != 2'b00))
                  | (i_mem_op & i_mem_half & i_lsb[0]);
`else
  // Alignment inputs are not used when the trap path is compiled out.
  logic lsb_unused;
  assign misalign   = 1'b0;
  assign lsb_unused = ^{i_lsb, i_mem_word, i_mem_half, misalign};
`endif

  // Next-state and state-decoded outputs.
  // NOTE: every output and next-state value gets a default first so no latches are inferred.
  always_comb begin
    state_d    = state_q;
    take_d     = take_q;
    cnt_clr    = 1'b0;
    o_ibus_cyc = 1'b0;
    o_dec_en   = 1'b0;
    o_rf_rreq  = 1'b0;
    o_dbus_cyc = 1'b0;
    o_cnt_en   = 1'b0;
    o_init     = 1'b0;
    o_cnt_done = 1'b0;
    o_rf_wen   = 1'b0;
    o_pc_en    = 1'b0;
    o_trap     = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        o_ibus_cyc = 1'b1;
        if (i_ibus_ack) begin
          o_dec_en = 1'b1;
          state_d  = ST_DEC;
        end
      end
      ST_DEC: begin
        o_rf_rreq = 1'b1;
        if (i_rf_ready) begin
          cnt_clr = 1'b1;
          state_d = (i_branch_op | i_slt_op | i_mem_op) ? ST_INIT : ST_RUN;
        end
      end
      ST_INIT: begin
        o_cnt_en = 1'b1;
        o_init   = 1'b1;
        if (cnt_last) begin
          take_d = take_now;
          if (misalign)      state_d = ST_TRAP;
          else if (i_mem_op) state_d = ST_MEM;
          else               state_d = ST_RUN;
        end
      end
      ST_MEM: begin
        o_dbus_cyc = 1'b1;
        if (i_dbus_ack) state_d = ST_RUN;
      end
      ST_RUN: begin
        o_cnt_en = 1'b1;
        o_rf_wen = i_rd_op;
        o_pc_en  = 1'b1;
        if (cnt_last) begin
          o_cnt_done = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_TRAP: begin
`ifdef SERV_EXEC_MISALIGN_EN
        o_trap   = 1'b1;
        o_cnt_en = 1'b1;
        o_pc_en  = 1'b1;
        if (cnt_last) begin
          o_cnt_done = 1'b1;
          state_d    = ST_FETCH;
        end
`else
        state_d = ST_FETCH;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched branch decision.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      take_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      take_q  <= take_d;
    end
  end

  assign o_take = take_q;

endmodule

// File: tb/tb_serv_exec_seq.sv
// Directed bench for serv_exec_seq: a W=1 and a W=4 instance share inputs;
// a cycle-level bus/RF responder counts cycles per phase for the selected one.
module tb_serv_exec_seq;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_ibus_ack, i_rf_ready, i_dbus_ack;
  logic       i_branch_op, i_cond_branch, i_mem_op, i_slt_op, i_rd_op;
  logic       i_mem_word, i_mem_half, i_alu_cmp;
  logic [1:0] i_lsb;

  logic       d1_ibus_cyc, d1_dec_en, d1_rf_rreq, d1_dbus_cyc, d1_cnt_en, d1_init;
  logic       d1_cnt_done, d1_take, d1_rf_wen, d1_pc_en, d1_trap;
  logic [4:0] d1_cnt;
  logic       d4_ibus_cyc, d4_dec_en, d4_rf_rreq, d4_dbus_cyc, d4_cnt_en, d4_init;
  logic       d4_cnt_done, d4_take, d4_rf_wen, d4_pc_en, d4_trap;
  logic [4:0] d4_cnt;

  bit         sel4 = 1'b0;
  logic       s_ibus_cyc, s_dec_en, s_rf_rreq, s_dbus_cyc, s_cnt_en, s_init;
  logic       s_cnt_done, s_take, s_rf_wen, s_pc_en, s_trap;
  logic [4:0] s_cnt;

  int passed = 0;
  int total  = 0;

  int n_fetch, n_dec_en, n_dec, n_init, n_dbus, n_run, n_trap, n_wen, n_done, n_cnt_err;
  logic run_take, fetch_after, timed_out, rst_dbus, rst_ibus;
  logic [4:0] rst_cnt;

  always #5 clk = ~clk;

  serv_exec_seq #(.W(1)) dut1 (
    .clk(clk), .i_rst_n(i_rst_n),
    .o_ibus_cyc(d1_ibus_cyc), .i_ibus_ack(i_ibus_ack), .o_dec_en(d1_dec_en),
    .o_rf_rreq(d1_rf_rreq), .i_rf_ready(i_rf_ready),
    .i_branch_op(i_branch_op), .i_cond_branch(i_cond_branch), .i_mem_op(i_mem_op),
    .i_slt_op(i_slt_op), .i_rd_op(i_rd_op), .i_mem_word(i_mem_word), .i_mem_half(i_mem_half),
    .i_alu_cmp(i_alu_cmp), .i_lsb(i_lsb),
    .o_dbus_cyc(d1_dbus_cyc), .i_dbus_ack(i_dbus_ack),
    .o_cnt(d1_cnt), .o_cnt_en(d1_cnt_en), .o_init(d1_init), .o_cnt_done(d1_cnt_done),
    .o_take(d1_take), .o_rf_wen(d1_rf_wen), .o_pc_en(d1_pc_en), .o_trap(d1_trap)
  );

  serv_exec_seq #(.W(4)) dut4 (
    .clk(clk), .i_rst_n(i_rst_n),
    .o_ibus_cyc(d4_ibus_cyc), .i_ibus_ack(i_ibus_ack), .o_dec_en(d4_dec_en),
    .o_rf_rreq(d4_rf_rreq), .i_rf_ready(i_rf_ready),
    .i_branch_op(i_branch_op), .i_cond_branch(i_cond_branch), .i_mem_op(i_mem_op),
    .i_slt_op(i_slt_op), .i_rd_op(i_rd_op), .i_mem_word(i_mem_word), .i_mem_half(i_mem_half),
    .i_alu_cmp(i_alu_cmp), .i_lsb(i_lsb),
    .o_dbus_cyc(d4_dbus_cyc), .i_dbus_ack(i_dbus_ack),
    .o_cnt(d4_cnt), .o_cnt_en(d4_cnt_en), .o_init(d4_init), .o_cnt_done(d4_cnt_done),
    .o_take(d4_take), .o_rf_wen(d4_rf_wen), .o_pc_en(d4_pc_en), .o_trap(d4_trap)
  );

  assign s_ibus_cyc = sel4 ? d4_ibus_cyc : d1_ibus_cyc;
  assign s_dec_en   = sel4 ? d4_dec_en   : d1_dec_en;
  assign s_rf_rreq  = sel4 ? d4_rf_rreq  : d1_rf_rreq;
  assign s_dbus_cyc = sel4 ? d4_dbus_cyc : d1_dbus_cyc;
  assign s_cnt_en   = sel4 ? d4_cnt_en   : d1_cnt_en;
  assign s_init     = sel4 ? d4_init     : d1_init;
  assign s_cnt_done = sel4 ? d4_cnt_done : d1_cnt_done;
  assign s_take     = sel4 ? d4_take     : d1_take;
  assign s_rf_wen   = sel4 ? d4_rf_wen   : d1_rf_wen;
  assign s_pc_en    = sel4 ? d4_pc_en    : d1_pc_en;
  assign s_trap     = sel4 ? d4_trap     : d1_trap;
  assign s_cnt      = sel4 ? d4_cnt      : d1_cnt;

  task automatic do_reset();
    i_rst_n = 1'b0;
    {i_ibus_ack, i_rf_ready, i_dbus_ack, i_branch_op, i_cond_branch, i_mem_op} = '0;
    {i_slt_op, i_rd_op, i_mem_word, i_mem_half, i_alu_cmp} = '0;
    i_lsb = 2'b00;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  // Plays ibus/RF/dbus for one instruction and counts cycles per phase.
  // rst_at > 0 asserts reset once that many dbus cycles have been seen.
  task automatic run_instr(input bit br, input bit cond, input bit mem, input bit slt,
                           input bit rd, input bit word, input bit half, input bit cmp,
                           input logic [1:0] lsb, input int ib_dly, input int rf_dly,
                           input int db_dly, input bit noise, input int rst_at);
    int   guard;
    int   wcur;
    bit   fin;
    logic [4:0] last;
    wcur = sel4 ? 4 : 1;
    last = sel4 ? 5'd28 : 5'd31;
    {n_fetch, n_dec_en, n_dec, n_init, n_dbus, n_run, n_trap, n_wen, n_done, n_cnt_err} = '0;
    run_take = 1'bx; fetch_after = 1'b0; timed_out = 1'b0;
    i_branch_op = br; i_cond_branch = cond; i_mem_op = mem; i_slt_op = slt;
    i_rd_op = rd; i_mem_word = word; i_mem_half = half;
    fin = 1'b0; guard = 0;
    while (!fin && guard < 300) begin
      @(negedge clk);
      guard++;
      i_ibus_ack = noise; i_dbus_ack = noise; i_rf_ready = noise;
      i_alu_cmp = ~cmp; i_lsb = 2'b00;
      #1;
      if (s_ibus_cyc) i_ibus_ack = (n_fetch == ib_dly);
      if (s_rf_rreq)  i_rf_ready = (n_dec == rf_dly);
      if (s_dbus_cyc) i_dbus_ack = (n_dbus == db_dly - 1);
      if (s_init && s_cnt == last) begin
        i_alu_cmp = cmp;
        i_lsb     = lsb;
      end
      #1;
      if (s_ibus_cyc) n_fetch++;
      if (s_dec_en)   n_dec_en++;
      if (s_rf_rreq)  n_dec++;
      if (s_init) begin
        if (s_cnt !== 5'(n_init * wcur)) n_cnt_err++;
        n_init++;
      end
      if (s_dbus_cyc) n_dbus++;
      if (s_trap) begin
        if (s_cnt !== 5'(n_trap * wcur)) n_cnt_err++;
        n_trap++;
      end else if (s_pc_en) begin
        if (s_cnt !== 5'(n_run * wcur)) n_cnt_err++;
        n_run++;
        run_take = s_take;
      end
      if (s_rf_wen)   n_wen++;
      if (s_cnt_done) begin
        n_done++;
        fin = 1'b1;
      end
      if (rst_at > 0 && n_dbus == rst_at) begin
        i_rst_n = 1'b0;
        #1;
        rst_dbus = s_dbus_cyc;
        rst_ibus = s_ibus_cyc;
        rst_cnt  = s_cnt;
        fin      = 1'b1;
      end
    end
    if (!fin) timed_out = 1'b1;
    else if (rst_at == 0) begin
      @(posedge clk);
      #1;
      fetch_after = s_ibus_cyc;
    end
  endtask

  task automatic test_reset();
    logic [16:0] outs;
    sel4 = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    i_ibus_ack = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    outs = {d1_ibus_cyc, d1_dec_en, d1_rf_rreq, d1_dbus_cyc, d1_cnt_en, d1_init,
            d1_cnt_done, d1_take, d1_rf_wen, d1_pc_en, d1_trap, d1_cnt, d4_ibus_cyc};
    total++;
    if (outs !== 17'd0) $display("FAIL reset_outputs: got %b want 0", outs); else passed++;
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    total++;
    if (d1_ibus_cyc !== 1'b0) $display("FAIL reset_idle_cycle: ibus_cyc=%b want 0", d1_ibus_cyc);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (d1_ibus_cyc !== 1'b1) $display("FAIL reset_then_fetch: ibus_cyc=%b want 1", d1_ibus_cyc);
    else passed++;
  endtask

  task automatic test_add();
    sel4 = 1'b0;
    do_reset();
    run_instr(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2, 0, 0, 0, 0);
    total++; if (n_fetch !== 3)  $display("FAIL add fetch_cycles: got %0d want 3", n_fetch); else passed++;
    total++; if (n_dec_en !== 1) $display("FAIL add dec_en: got %0d want 1", n_dec_en); else passed++;
    total++; if (n_dec !== 1)    $display("FAIL add dec_cycles: got %0d want 1", n_dec); else passed++;
    total++; if (n_init !== 0)   $display("FAIL add init_cycles: got %0d want 0", n_init); else passed++;
    total++; if (n_run !== 32)   $display("FAIL add run_cycles: got %0d want 32", n_run); else passed++;
    total++; if (n_wen !== 32)   $display("FAIL add rf_wen: got %0d want 32", n_wen); else passed++;
    total++; if (n_done !== 1)   $display("FAIL add cnt_done: got %0d want 1", n_done); else passed++;
    total++; if (n_cnt_err !== 0) $display("FAIL add cnt_seq: got %0d errs want 0", n_cnt_err); else passed++;
    total++; if (fetch_after !== 1'b1) $display("FAIL add next_fetch: got %b want 1", fetch_after); else passed++;
  endtask

  task automatic test_branch();
    sel4 = 1'b0;
    do_reset();
    run_instr(1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0);
    total++; if (n_dec !== 2)      $display("FAIL beq dec_cycles: got %0d want 2", n_dec); else passed++;
    total++; if (n_init !== 32)    $display("FAIL beq init_cycles: got %0d want 32", n_init); else passed++;
    total++; if (n_run !== 32)     $display("FAIL beq run_cycles: got %0d want 32", n_run); else passed++;
    total++; if (run_take !== 1'b1) $display("FAIL beq_taken take: got %b want 1", run_take); else passed++;
    total++; if (n_wen !== 0)      $display("FAIL beq rf_wen: got %0d want 0", n_wen); else passed++;
    total++; if (n_cnt_err !== 0)  $display("FAIL beq cnt_seq: got %0d errs want 0", n_cnt_err); else passed++;
    do_reset();
    run_instr(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    total++; if (run_take !== 1'b0) $display("FAIL beq_not_taken take: got %b want 0", run_take); else passed++;
    total++; if (n_run !== 32)     $display("FAIL beq_not_taken run: got %0d want 32", n_run); else passed++;
    do_reset();
    run_instr(1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    total++; if (run_take !== 1'b1) $display("FAIL jal take: got %b want 1", run_take); else passed++;
    total++; if (n_wen !== 32)     $display("FAIL jal rf_wen: got %0d want 32", n_wen); else passed++;
  endtask

  task automatic test_mem();
    sel4 = 1'b0;
    do_reset();
    run_instr(0, 0, 1, 0, 1, 1, 0, 0, 2'b00, 0, 0, 5, 0, 0);
    total++; if (n_init !== 32) $display("FAIL lw init_cycles: got %0d want 32", n_init); else passed++;
    total++; if (n_dbus !== 5)  $display("FAIL lw dbus_cycles: got %0d want 5", n_dbus); else passed++;
    total++; if (n_run !== 32)  $display("FAIL lw run_cycles: got %0d want 32", n_run); else passed++;
    total++; if (n_wen !== 32)  $display("FAIL lw rf_wen: got %0d want 32", n_wen); else passed++;
    total++; if (n_cnt_err !== 0) $display("FAIL lw cnt_seq: got %0d errs want 0", n_cnt_err); else passed++;
    do_reset();
    run_instr(0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0);
    total++; if (n_dbus !== 1)  $display("FAIL sw dbus_cycles: got %0d want 1", n_dbus); else passed++;
    total++; if (n_wen !== 0)   $display("FAIL sw rf_wen: got %0d want 0", n_wen); else passed++;
    total++; if (n_run !== 32)  $display("FAIL sw run_cycles: got %0d want 32", n_run); else passed++;
    do_reset();
    run_instr(0, 0, 0, 1, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0);
    total++; if (n_init !== 32) $display("FAIL slt init_cycles: got %0d want 32", n_init); else passed++;
    total++; if (n_dbus !== 0)  $display("FAIL slt dbus_cycles: got %0d want 0", n_dbus); else passed++;
    total++; if (run_take !== 1'b0) $display("FAIL slt take: got %b want 0", run_take); else passed++;
  endtask

  task automatic test_w4();
    sel4 = 1'b1;
    do_reset();
    run_instr(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    total++; if (n_fetch !== 1) $display("FAIL w4_add fetch_cycles: got %0d want 1", n_fetch); else passed++;
    total++; if (n_run !== 8)   $display("FAIL w4_add run_cycles: got %0d want 8", n_run); else passed++;
    total++; if (n_wen !== 8)   $display("FAIL w4_add rf_wen: got %0d want 8", n_wen); else passed++;
    total++; if (n_dbus !== 0)  $display("FAIL w4_add stray_dbus: got %0d want 0", n_dbus); else passed++;
    total++; if (n_cnt_err !== 0) $display("FAIL w4_add cnt_seq: got %0d errs want 0", n_cnt_err); else passed++;
    total++; if (fetch_after !== 1'b1) $display("FAIL w4_add next_fetch: got %b want 1", fetch_after); else passed++;
    do_reset();
    run_instr(0, 0, 1, 0, 1, 1, 0, 0, 2'b00, 0, 0, 2, 0, 0);
    total++; if (n_init !== 8)  $display("FAIL w4_lw init_cycles: got %0d want 8", n_init); else passed++;
    total++; if (n_dbus !== 2)  $display("FAIL w4_lw dbus_cycles: got %0d want 2", n_dbus); else passed++;
    total++; if (n_run !== 8)   $display("FAIL w4_lw run_cycles: got %0d want 8", n_run); else passed++;
    sel4 = 1'b0;
  endtask

  task automatic test_misalign();
    sel4 = 1'b0;
    do_reset();
    run_instr(0, 0, 1, 0, 1, 1, 0, 0, 2'b10, 0, 0, 2, 0, 0);
`ifdef SERV_EXEC_MISALIGN_EN
    total++; if (n_trap !== 32) $display("FAIL lw_mis trap_cycles: got %0d want 32", n_trap); else passed++;
    total++; if (n_dbus !== 0)  $display("FAIL lw_mis dbus_cycles: got %0d want 0", n_dbus); else passed++;
    total++; if (n_wen !== 0)   $display("FAIL lw_mis rf_wen: got %0d want 0", n_wen); else passed++;
    total++; if (n_run !== 0)   $display("FAIL lw_mis run_cycles: got %0d want 0", n_run); else passed++;
`else
    total++; if (n_trap !== 0)  $display("FAIL lw_mis trap_cycles: got %0d want 0", n_trap); else passed++;
    total++; if (n_dbus !== 2)  $display("FAIL lw_mis dbus_cycles: got %0d want 2", n_dbus); else passed++;
    total++; if (n_run !== 32)  $display("FAIL lw_mis run_cycles: got %0d want 32", n_run); else passed++;
`endif
    total++; if (n_done !== 1)  $display("FAIL lw_mis cnt_done: got %0d want 1", n_done); else passed++;
    total++; if (n_cnt_err !== 0) $display("FAIL lw_mis cnt_seq: got %0d errs want 0", n_cnt_err); else passed++;
  endtask

  task automatic test_back_to_back();
    sel4 = 1'b0;
    do_reset();
    run_instr(1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0);
    run_instr(0, 0, 1, 0, 1, 1, 0, 0, 2'b00, 1, 0, 3, 0, 0);
    total++; if (n_fetch !== 2) $display("FAIL b2b fetch_cycles: got %0d want 2", n_fetch); else passed++;
    total++; if (n_dbus !== 3)  $display("FAIL b2b dbus_cycles: got %0d want 3", n_dbus); else passed++;
    total++; if (run_take !== 1'b0) $display("FAIL b2b take_cleared: got %b want 0", run_take); else passed++;
    total++; if (n_wen !== 32)  $display("FAIL b2b rf_wen: got %0d want 32", n_wen); else passed++;
  endtask

  task automatic test_reset_mid_mem();
    sel4 = 1'b0;
    do_reset();
    run_instr(0, 0, 1, 0, 1, 1, 0, 0, 2'b00, 0, 0, 10, 0, 2);
    total++; if (timed_out !== 1'b0) $display("FAIL rst_mem reached_mem: timed_out=%b want 0", timed_out); else passed++;
    total++; if (rst_dbus !== 1'b0) $display("FAIL rst_mem dbus_drop: got %b want 0", rst_dbus); else passed++;
    total++; if (rst_cnt !== 5'd0)  $display("FAIL rst_mem cnt: got %0d want 0", rst_cnt); else passed++;
    total++; if (rst_ibus !== 1'b0) $display("FAIL rst_mem ibus: got %b want 0", rst_ibus); else passed++;
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    total++; if (d1_ibus_cyc !== 1'b0) $display("FAIL rst_mem idle: ibus_cyc=%b want 0", d1_ibus_cyc); else passed++;
    @(negedge clk);
    #1;
    total++; if (d1_ibus_cyc !== 1'b1) $display("FAIL rst_mem fetch: ibus_cyc=%b want 1", d1_ibus_cyc); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_mem();
    test_w4();
    test_misalign();
    test_back_to_back();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
